// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing output bundle between generator and pixel pipeline
interface vga_timing_if #(
   parameter int CNT_W = 11
) ();
   logic             hsync;
   logic             vsync;
   logic             valid;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             sof;
   logic             eol;
   logic [15:0]      frame_cnt;

   modport master (
      output hsync, vsync, valid, h_cnt, v_cnt, sof, eol, frame_cnt
   );

   modport slave (
      input hsync, vsync, valid, h_cnt, v_cnt, sof, eol, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/DVI raster timing generator with pixel clock-enable
module vga_timing_gen #(
   parameter int          H_ACTIVE   = 640,
   parameter int          H_FP       = 16,
   parameter int          H_SYNC     = 96,
   parameter int          H_BP       = 48,
   parameter int          V_ACTIVE   = 480,
   parameter int          V_FP       = 10,
   parameter int          V_SYNC     = 2,
   parameter int          V_BP       = 33,
   parameter bit          HS_POL     = 1'b0,
   parameter bit          VS_POL     = 1'b0,
   parameter int          CNT_W      = 11,
   parameter int unsigned SYNC_DELAY = 0
) (
   input  logic         pclk,
   input  logic         reset,
   input  logic         ce,
   input  logic         restart,
   vga_timing_if.master vid
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam bit HS_IDLE  = ~HS_POL;
   localparam bit VS_IDLE  = ~VS_POL;

   logic [CNT_W-1:0] x, y;
   logic [15:0]      frame_cnt;
   logic             x_last, y_last;

   assign x_last = (x == CNT_W'(H_TOTAL - 1));
   assign y_last = (y == CNT_W'(V_TOTAL - 1));

   always_ff @(posedge pclk) begin
      if (reset) begin
         x         <= '0;
         y         <= '0;
         frame_cnt <= '0;
      end else if (restart) begin
         x <= '0;
         y <= '0;
      end else if (ce) begin
         if (x_last) begin
            x <= '0;
            if (y_last) begin
               y         <= '0;
               frame_cnt <= frame_cnt + 16'd1;
            end else begin
               y <= y + CNT_W'(1);
            end
         end else begin
            x <= x + CNT_W'(1);
         end
      end
   end

   logic hs_act, vs_act, de, sof_d, eol_d;

   always_comb begin
      hs_act = (x >= CNT_W'(HS_START)) && (x < CNT_W'(HS_END));
      vs_act = (y >= CNT_W'(VS_START)) && (y < CNT_W'(VS_END));
      de     = (x < CNT_W'(H_ACTIVE)) && (y < CNT_W'(V_ACTIVE));
      sof_d  = (x == '0) && (y == '0);
      eol_d  = (x == CNT_W'(H_ACTIVE - 1)) && (y < CNT_W'(V_ACTIVE));
   end

   // First decode stage: every output is registered here, so no input reaches an output combinationally.
   logic             hs_r, vs_r, de_r, sof_r, eol_r;
   logic [CNT_W-1:0] h_cnt_r, v_cnt_r;

   always_ff @(posedge pclk) begin
      if (reset) begin
         hs_r    <= HS_IDLE;
         vs_r    <= VS_IDLE;
         de_r    <= 1'b0;
         h_cnt_r <= '0;
         v_cnt_r <= '0;
         sof_r   <= 1'b0;
         eol_r   <= 1'b0;
      end else if (ce) begin
         hs_r    <= hs_act ? HS_POL : HS_IDLE;
         vs_r    <= vs_act ? VS_POL : VS_IDLE;
         de_r    <= de;
         h_cnt_r <= de ? x : '0;
         v_cnt_r <= de ? y : '0;
         sof_r   <= sof_d;
         eol_r   <= eol_d;
      end
   end

   assign vid.h_cnt     = h_cnt_r;
   assign vid.v_cnt     = v_cnt_r;
   assign vid.sof       = sof_r;
   assign vid.eol       = eol_r;
   assign vid.frame_cnt = frame_cnt;

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign vid.hsync = hs_r;
         assign vid.vsync = vs_r;
         assign vid.valid = de_r;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe, de_pipe;

         // Only the sync/enable group is delayed; coordinates and strobes stay on the undelayed timeline.
         always_ff @(posedge pclk) begin
            if (reset) begin
               hs_pipe <= {SYNC_DELAY{HS_IDLE}};
               vs_pipe <= {SYNC_DELAY{VS_IDLE}};
               de_pipe <= '0;
            end else if (ce) begin
               hs_pipe[0] <= hs_r;
               vs_pipe[0] <= vs_r;
               de_pipe[0] <= de_r;
               for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                  hs_pipe[i] <= hs_pipe[i-1];
                  vs_pipe[i] <= vs_pipe[i-1];
                  de_pipe[i] <= de_pipe[i-1];
               end
            end
         end

         assign vid.hsync = hs_pipe[SYNC_DELAY-1];
         assign vid.vsync = vs_pipe[SYNC_DELAY-1];
         assign vid.valid = de_pipe[SYNC_DELAY-1];
      end
   endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for default, small-mode and delayed-sync generators
module tb_vga_timing_gen;
   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic reset_def, ce_def, restart_def;
   logic reset_sm,  ce_sm,  restart_sm;
   logic reset_dly, ce_dly, restart_dly;

   vga_timing_if if_def ();
   vga_timing_if if_sm ();
   vga_timing_if if_dly ();

   vga_timing_gen dut_def (
      .pclk(pclk), .reset(reset_def), .ce(ce_def), .restart(restart_def), .vid(if_def)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_sm (
      .pclk(pclk), .reset(reset_sm), .ce(ce_sm), .restart(restart_sm), .vid(if_sm)
   );

   vga_timing_gen #(
      .SYNC_DELAY(3)
   ) dut_dly (
      .pclk(pclk), .reset(reset_dly), .ce(ce_dly), .restart(restart_dly), .vid(if_dly)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   int hs_low, hs_first, eol_idx, eol_n, val_n, glitch, e1, e2;
   logic prev_eol, ce_was;
   logic [42:0] cur, prev;

   initial begin
      reset_def = 1'b1; ce_def = 1'b1; restart_def = 1'b0;
      reset_sm  = 1'b1; ce_sm  = 1'b1; restart_sm  = 1'b0;
      reset_dly = 1'b1; ce_dly = 1'b1; restart_dly = 1'b0;
      repeat (3) tick();

      check("rst_hsync",  32'(if_def.hsync), 1);
      check("rst_vsync",  32'(if_def.vsync), 1);
      check("rst_valid",  32'(if_def.valid), 0);
      check("rst_h_cnt",  32'(if_def.h_cnt), 0);
      check("rst_v_cnt",  32'(if_def.v_cnt), 0);
      check("rst_sof",    32'(if_def.sof), 0);
      check("rst_eol",    32'(if_def.eol), 0);
      check("rst_frame",  32'(if_def.frame_cnt), 0);
      check("rst_sm_hs",  32'(if_sm.hsync), 0);
      check("rst_sm_vs",  32'(if_sm.vsync), 0);
      check("rst_dly_hs", 32'(if_dly.hsync), 1);

      // Default mode, one full line with ce held high
      reset_def = 1'b0;
      hs_low = 0; hs_first = -1; eol_idx = -1; eol_n = 0; val_n = 0;
      for (int k = 0; k < 800; k++) begin
         tick();
         if (k == 0) begin
            check("first_valid", 32'(if_def.valid), 1);
            check("first_sof",   32'(if_def.sof), 1);
            check("first_h",     32'(if_def.h_cnt), 0);
            check("first_v",     32'(if_def.v_cnt), 0);
         end
         if (k == 639) check("h_639", 32'(if_def.h_cnt), 639);
         if (k == 700) check("h_outside", 32'(if_def.h_cnt), 0);
         if (!if_def.hsync) begin
            hs_low++;
            if (hs_first < 0) hs_first = k;
         end
         if (if_def.eol) begin
            eol_n++;
            eol_idx = k;
         end
         if (if_def.valid) val_n++;
      end
      check("hs_low_len",  32'(hs_low), 96);
      check("hs_first_x",  32'(hs_first), 656);
      check("eol_x",       32'(eol_idx), 639);
      check("eol_count",   32'(eol_n), 1);
      check("valid_count", 32'(val_n), 640);
      tick();
      check("line1_v",   32'(if_def.v_cnt), 1);
      check("line1_h",   32'(if_def.h_cnt), 0);
      check("line1_sof", 32'(if_def.sof), 0);

      // Default mode, ce on every 4th clock
      reset_def = 1'b1;
      tick();
      reset_def = 1'b0;
      ce_def = 1'b1;
      glitch = 0; hs_low = 0; e1 = -1; e2 = -1; prev_eol = 1'b0; prev = '0;
      for (int k = 0; k < 6500; k++) begin
         tick();
         ce_was = ce_def;
         cur = {if_def.hsync, if_def.vsync, if_def.valid, if_def.h_cnt, if_def.v_cnt,
                if_def.sof, if_def.eol, if_def.frame_cnt};
         if (k > 0 && !ce_was && cur !== prev) glitch++;
         prev = cur;
         if (k < 3200 && !if_def.hsync) hs_low++;
         if (if_def.eol && !prev_eol) begin
            if (e1 < 0) e1 = k;
            else if (e2 < 0) e2 = k;
         end
         prev_eol = if_def.eol;
         if (k == 40) check("ce4_h_10", 32'(if_def.h_cnt), 10);
         ce_def = ((k + 1) % 4 == 0);
      end
      ce_def = 1'b1;
      check("ce4_glitch",   32'(glitch), 0);
      check("ce4_hs_low",   32'(hs_low), 384);
      check("ce4_eol_time", 32'(e1), 2556);
      check("ce4_line_per", 32'(e2 - e1), 3200);

      // Small mode, H_TOTAL=7, V_TOTAL=5, active-high syncs
      reset_sm = 1'b0;
      for (int k = 0; k < 79; k++) begin
         int x, y;
         logic de;
         tick();
         x = k % 7;
         y = (k / 7) % 5;
         de = (x < 4) && (y < 2);
         if (k < 70) begin
            check($sformatf("sm_hs_%0d", k),  32'(if_sm.hsync), 32'(x == 5));
            check($sformatf("sm_vs_%0d", k),  32'(if_sm.vsync), 32'(y == 3));
            check($sformatf("sm_de_%0d", k),  32'(if_sm.valid), 32'(de));
            check($sformatf("sm_h_%0d", k),   32'(if_sm.h_cnt), de ? 32'(x) : 0);
            check($sformatf("sm_v_%0d", k),   32'(if_sm.v_cnt), de ? 32'(y) : 0);
            check($sformatf("sm_sof_%0d", k), 32'(if_sm.sof), 32'(x == 0 && y == 0));
            check($sformatf("sm_eol_%0d", k), 32'(if_sm.eol), 32'(x == 3 && y < 2));
            check($sformatf("sm_fc_%0d", k),  32'(if_sm.frame_cnt), 32'((k + 1) / 35));
         end
      end

      // Restart mid-line with ce low: outputs hold, next ce step presents frame start
      ce_sm = 1'b0;
      restart_sm = 1'b1;
      tick();
      check("rs_hold_sof", 32'(if_sm.sof), 0);
      check("rs_hold_h",   32'(if_sm.h_cnt), 1);
      check("rs_hold_fc",  32'(if_sm.frame_cnt), 2);
      restart_sm = 1'b0;
      ce_sm = 1'b1;
      tick();
      check("rs_sof",   32'(if_sm.sof), 1);
      check("rs_valid", 32'(if_sm.valid), 1);
      check("rs_h",     32'(if_sm.h_cnt), 0);
      check("rs_v",     32'(if_sm.v_cnt), 0);
      check("rs_fc",    32'(if_sm.frame_cnt), 2);
      tick();
      check("rs_next_sof", 32'(if_sm.sof), 0);
      check("rs_next_h",   32'(if_sm.h_cnt), 1);

      // SYNC_DELAY=3: sync group trails coordinates by three ce steps
      reset_dly = 1'b0;
      for (int k = 0; k < 700; k++) begin
         tick();
         if (k <= 3) check($sformatf("dly_valid_%0d", k), 32'(if_dly.valid), 32'(k == 3));
         if (k == 0) check("dly_sof", 32'(if_dly.sof), 1);
         if (k == 642) check("dly_valid_642", 32'(if_dly.valid), 1);
         if (k == 643) check("dly_valid_643", 32'(if_dly.valid), 0);
         if (k == 658) check("dly_hs_658", 32'(if_dly.hsync), 1);
         if (k == 659) check("dly_hs_659", 32'(if_dly.hsync), 0);
      end
      reset_dly = 1'b1;
      tick();
      check("dly_rst_hs",    32'(if_dly.hsync), 1);
      check("dly_rst_vs",    32'(if_dly.vsync), 1);
      check("dly_rst_valid", 32'(if_dly.valid), 0);
      check("dly_rst_h",     32'(if_dly.h_cnt), 0);
      reset_dly = 1'b0;
      tick();
      check("dly_rel_sof",   32'(if_dly.sof), 1);
      check("dly_rel_valid", 32'(if_dly.valid), 0);
      check("dly_rel_hs",    32'(if_dly.hsync), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
